// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART host command path.
//   CMD_WRITE / CMD_READ : first byte of a host frame
//   RSP_ACK / RSP_NAK    : single-byte responses returned to the host
//   resp_state_t         : frame decoder state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } resp_state_t;

endpackage

// File: rtl/uart_reg_responder_byte_timeout.sv
// -----------------------------------------------------------------------------
// byte_timeout
// Inter-byte watchdog. Counts clk cycles while 'run' is high and no byte
// arrives; flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1.
// A byte arriving on that same cycle ('clear') suppresses the expiry.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   clear    in   byte seen this cycle; restart the count
//   run      in   a frame is in progress; count idle cycles
//   expire_o out  combinational: idle limit reached this cycle
// -----------------------------------------------------------------------------
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire_o
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign expire_o = run & ~clear & (r_cnt == TERM);

  // The count restarts after expiry so the block stays self-consistent
  // even if the owner keeps 'run' asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear || !run || expire_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// -----------------------------------------------------------------------------
// uart_reg_responder
// Decodes host command frames arriving byte-by-byte from uart_rx into
// accesses on a small 8-bit register file and returns one response byte per
// frame towards uart_tx.
//   Write: 'W' addr data -> ACK (NAK if addr out of range)
//   Read : 'R' addr      -> regs[addr] (NAK if addr out of range)
//   Other first byte     -> NAK
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   rx_valid   in   one-cycle strobe, rx_data valid
//   rx_data    in   received byte
//   tx_valid   out  response byte available, held until accepted
//   tx_ready   in   uart_tx accepts when tx_valid & tx_ready
//   tx_data    out  response byte, holds its last value when idle
//   regs_o     out  register file, reg k at [8k+7:8k]
//   overrun_o  out  one-cycle pulse: byte dropped while a response is pending
//   timeout_o  out  one-cycle pulse: partial frame abandoned
// -----------------------------------------------------------------------------
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int         NUM_REGS       = 8,
  parameter logic [7:0] REG_RESET      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  overrun_o,
  output logic                  timeout_o
);

  // Full 8-bit compare: with NUM_REGS=256 every address is in range.
  function automatic logic addr_ok(input logic [7:0] a);
    return (int'(a) < NUM_REGS);
  endfunction

  resp_state_t                   r_state;
  resp_state_t                   w_state_nxt;
  logic                          r_is_write;
  logic [7:0]                    r_addr;
  logic [7:0]                    r_tx_data;
  logic [NUM_REGS-1:0][7:0]      r_regs;
  logic                          r_overrun;
  logic                          r_timeout;

  logic                          w_latch_cmd;
  logic                          w_latch_addr;
  logic                          w_load_resp;
  logic [7:0]                    w_resp_nxt;
  logic                          w_wr_en;
  logic                          w_overrun;
  logic                          w_timeout;
  logic                          w_run;
  logic                          w_expire;
  logic [7:0]                    w_rd_data;

  assign tx_valid  = (r_state == RESP);
  assign tx_data   = r_tx_data;
  assign regs_o    = r_regs;
  assign overrun_o = r_overrun;
  assign timeout_o = r_timeout;

  // Only the address/data phases are bounded; IDLE waits forever and RESP
  // is held by the transmitter.
  assign w_run = (r_state == ADDR) || (r_state == DATA);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (rx_valid),
    .run     (w_run),
    .expire_o(w_expire)
  );

  // Read mux indexed by the byte on the wire, so read data is captured at
  // the same edge that consumes the address byte.
  always_comb begin
    w_rd_data = REG_RESET;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rx_data) == k) begin
        w_rd_data = r_regs[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_latch_cmd  = 1'b0;
    w_latch_addr = 1'b0;
    w_load_resp  = 1'b0;
    w_resp_nxt   = RSP_NAK;
    w_wr_en      = 1'b0;
    w_overrun    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            w_latch_cmd = 1'b1;
            w_state_nxt = ADDR;
          end else begin
            w_load_resp = 1'b1;
            w_resp_nxt  = RSP_NAK;
            w_state_nxt = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          w_latch_addr = 1'b1;
          if (r_is_write) begin
            w_state_nxt = DATA;
          end else begin
            w_load_resp = 1'b1;
            w_resp_nxt  = addr_ok(rx_data) ? w_rd_data : RSP_NAK;
            w_state_nxt = RESP;
          end
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (rx_valid) begin
          w_wr_en     = addr_ok(r_addr);
          w_load_resp = 1'b1;
          w_resp_nxt  = addr_ok(r_addr) ? RSP_ACK : RSP_NAK;
          w_state_nxt = RESP;
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RESP: begin
        // No rx backpressure exists, so anything arriving now is lost.
        w_overrun = rx_valid;
        if (tx_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_tx_data  <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_overrun <= w_overrun;
      r_timeout <= w_timeout;
      if (w_latch_cmd) begin
        r_is_write <= (rx_data == CMD_WRITE);
      end
      if (w_latch_addr) begin
        r_addr <= rx_data;
      end
      if (w_load_resp) begin
        r_tx_data <= w_resp_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= {NUM_REGS{REG_RESET}};
    end else if (w_wr_en) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (int'(r_addr) == k) begin
          r_regs[k] <= rx_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
module tb_uart_reg_responder;

  localparam int         NR = 8;
  localparam int         TC = 16;
  localparam logic [7:0] RR = 8'h00;
  localparam int         NV = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            tx_ready = 1'b0;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic [NR*8-1:0] regs_o;
  logic            overrun_o;
  logic            timeout_o;

  uart_reg_responder #(
    .NUM_REGS      (NR),
    .REG_RESET     (RR),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .regs_o   (regs_o),
    .overrun_o(overrun_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Event counters sampled on the inactive edge.
  int ov_cnt = 0;
  int to_cnt = 0;
  int txv_cnt = 0;
  always @(negedge clk) begin
    if (overrun_o) ov_cnt++;
    if (timeout_o) to_cnt++;
    if (tx_valid)  txv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural reference: register contents and protocol rules.
  logic [7:0] model_regs [NR];

  function automatic void model_reset();
    for (int k = 0; k < NR; k++) model_regs[k] = RR;
  endfunction

  function automatic logic [7:0] model_cmd(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2);
    if (b0 == 8'h57) begin
      if (int'(b1) < NR) begin
        model_regs[int'(b1)] = b2;
        return 8'h06;
      end
      return 8'h15;
    end else if (b0 == 8'h52) begin
      if (int'(b1) < NR) return model_regs[int'(b1)];
      return 8'h15;
    end
    return 8'h15;
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = model_regs[k];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called and returns at posedge+1; the byte is consumed at the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model must already have been updated for this command.
  task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int n, input int stall, input string name,
                         input logic [7:0] exp);
    int bad;
    send_byte(b0);
    if (n > 1) send_byte(b1);
    if (n > 2) send_byte(b2);
    check({name, " latency"}, tx_valid, 1'b1);
    check({name, " data"}, tx_data, exp);
    check({name, " regs"}, regs_o, model_flat());
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      step();
      if (tx_valid !== 1'b1 || tx_data !== exp) bad++;
    end
    if (stall > 0) check({name, " hold"}, bad, 0);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check({name, " release"}, tx_valid, 1'b0);
  endtask

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [7:0] e;
    int ov0, to0, tv0, bad;

    vecs[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h06};
    vecs[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5};
    vecs[2] = '{8'h57, 8'h08, 8'hFF, 3, 8'h15};
    vecs[3] = '{8'h52, 8'h09, 8'h00, 2, 8'h15};
    vecs[4] = '{8'h41, 8'h00, 8'h00, 1, 8'h15};
    vecs[5] = '{8'h52, 8'h00, 8'h00, 2, 8'h00};
    vecs[6] = '{8'h57, 8'h07, 8'h3C, 3, 8'h06};
    vecs[7] = '{8'h52, 8'h07, 8'h00, 2, 8'h3C};
    vecs[8] = '{8'h52, 8'hFF, 8'h00, 2, 8'h15};
    vecs[9] = '{8'h57, 8'h00, 8'h11, 3, 8'h06};

    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_data", tx_data, 8'h00);
    check("reset regs", regs_o, model_flat());
    check("reset overrun", overrun_o, 1'b0);
    check("reset timeout", timeout_o, 1'b0);
    rst_n = 1'b1;
    step();
    check("post-reset tx_valid", tx_valid, 1'b0);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      void'(model_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2));
      run_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, i % 3,
              $sformatf("vec%0d", i), vecs[i].exp);
    end
    check("reg3 byte lane", regs_o[31:24], 8'hA5);

    // Backpressure with a byte dropped mid-response, then one more on the
    // handshake cycle itself.
    ov0 = ov_cnt;
    send_byte(8'h52);
    send_byte(8'h05);
    check("bp latency", tx_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) begin
        rx_valid = 1'b1;
        rx_data  = 8'h57;
      end
      step();
      rx_valid = 1'b0;
      if (tx_valid !== 1'b1 || tx_data !== RR) bad++;
    end
    check("bp hold", bad, 0);
    check("bp overrun once", ov_cnt - ov0, 1);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h57;
    step();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    check("bp release", tx_valid, 1'b0);
    step();
    check("handshake overrun", ov_cnt - ov0, 2);
    check("bp no write", regs_o, model_flat());
    e = model_cmd(8'h52, 8'h03, 8'h00);
    run_cmd(8'h52, 8'h03, 8'h00, 2, 0, "after overrun", e);

    // Timeout abandons a partial write
    to0 = to_cnt;
    tv0 = txv_cnt;
    send_byte(8'h57);
    send_byte(8'h02);
    repeat (TC + 4) step();
    check("timeout pulse", to_cnt - to0, 1);
    check("timeout no tx", txv_cnt - tv0, 0);
    check("timeout no write", regs_o, model_flat());
    e = model_cmd(8'h52, 8'h02, 8'h00);
    run_cmd(8'h52, 8'h02, 8'h00, 2, 0, "after timeout", e);

    // Byte on the terminal-count cycle is processed
    to0 = to_cnt;
    send_byte(8'h57);
    send_byte(8'h02);
    repeat (TC - 1) step();
    void'(model_cmd(8'h57, 8'h02, 8'h5A));
    send_byte(8'h5A);
    check("terminal latency", tx_valid, 1'b1);
    check("terminal data", tx_data, 8'h06);
    check("terminal regs", regs_o, model_flat());
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    step();
    check("terminal no timeout", to_cnt - to0, 0);

    // Async reset mid-frame
    e = model_cmd(8'h57, 8'h01, 8'h77);
    run_cmd(8'h57, 8'h01, 8'h77, 3, 0, "pre-reset write", e);
    send_byte(8'h57);
    send_byte(8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async regs", regs_o, model_flat());
    check("async tx_valid", tx_valid, 1'b0);
    check("async tx_data", tx_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tv0 = txv_cnt;
    to0 = to_cnt;
    repeat (TC + 4) step();
    check("after reset no tx", txv_cnt - tv0, 0);
    check("after reset no timeout", to_cnt - to0, 0);
    e = model_cmd(8'h52, 8'h01, 8'h00);
    run_cmd(8'h52, 8'h01, 8'h00, 2, 0, "after reset read", e);

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b0, b1, b2;
      int kind, n;
      kind = $urandom_range(0, 3);
      b1 = 8'($urandom_range(0, 11));
      b2 = 8'($urandom);
      if (kind == 1) begin
        b0 = 8'h52;
        n  = 2;
      end else if (kind == 2) begin
        do b0 = 8'($urandom); while (b0 == 8'h57 || b0 == 8'h52);
        n = 1;
      end else begin
        b0 = 8'h57;
        n  = 3;
      end
      e = model_cmd(b0, b1, b2);
      run_cmd(b0, b1, b2, n, $urandom_range(0, 3), $sformatf("rnd%0d", i), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
- Host-facing responder sitting between uart_rx (byte in) and uart_tx (byte out) on the board top level.
- Decodes a 2-3 byte command protocol from the host into read/write accesses on a small internal 8-bit register file, and returns one response byte per command.
- The register file is exposed as a flat output bus, e.g. to drive LED_s or the pwm compare values.

Parameters:
- NUM_REGS, 8, number of 8-bit registers (1..256); valid addresses 0..NUM_REGS-1
- REG_RESET, 8'h00, reset value of every register
- TIMEOUT_CYCLES, 5_000_000, idle clk cycles allowed between bytes of one frame (100 ms @ 50 MHz); must be >= 2

Ports:
- clk  in  1  system clock (CLK50MHZ)
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid (uart_rx write)
- rx_data  in  8  received byte
- tx_valid  out  1  response byte available; held until accepted
- tx_ready  in  1  uart_tx accepts tx_data when tx_valid & tx_ready
- tx_data  out  8  response byte; stable while tx_valid
- regs_o  out  NUM_REGS*8  register file, reg k at bits [8k+7:8k]
- overrun_o  out  1  one-cycle pulse: rx byte dropped
- timeout_o  out  1  one-cycle pulse: partial frame abandoned

Behaviour:
- Protocol:
  - Write: 'W'(0x57), addr, data -> ACK 0x06, or NAK 0x15 if addr >= NUM_REGS.
  - Read: 'R'(0x52), addr -> regs[addr], or NAK if addr >= NUM_REGS.
  - Any other first byte -> NAK.
- Reset (reset=0, async):
  - state=IDLE; tx_valid=0; tx_data=0; all regs=REG_RESET.
  - overrun_o=0; timeout_o=0; timeout counter=0.
  - Reset mid-frame or mid-response discards everything; no response is emitted after release.
- FSM states are IDLE, ADDR, DATA, RESP; a byte is consumed on a cycle with rx_valid=1.
  - IDLE:
    - 'W' or 'R' -> latch cmd, go to ADDR.
    - Other byte -> resp=NAK, go to RESP.
  - ADDR, on byte:
    - Latch addr.
    - If cmd=R: resp = (addr<NUM_REGS) ? regs[addr] : NAK, go to RESP.
    - If cmd=W: go to DATA.
  - DATA, on byte:
    - If addr valid, write regs[addr]=byte; the new value is visible on regs_o the next cycle.
    - resp = ACK if addr valid, else NAK; go to RESP.
  - RESP:
    - tx_valid=1, tx_data=resp.
    - On tx_valid & tx_ready -> tx_valid=0 on the next edge, go to IDLE.
- Latency: final byte strobe at cycle N -> tx_valid=1 at N+1. Read data is sampled at the final-byte edge, not later.
- No rx backpressure: rx_valid while in RESP (including the handshake cycle) -> byte discarded, overrun_o=1 for one cycle, state unaffected.
- Timeout:
  - Counter clears on every rx_valid and in IDLE/RESP; it increments in ADDR/DATA.
  - At TIMEOUT_CYCLES-1 with no rx_valid -> go to IDLE, timeout_o=1 for one cycle, no response.
  - rx_valid on the terminal-count cycle wins: the byte is processed and there is no timeout.
- Address compare uses the full 8-bit addr; with NUM_REGS=256 every address is valid.
- tx_data holds its last value when tx_valid=0.

Decomposition:
- uart_pkg gains:
  - CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15
  - typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} resp_state_t
- One sub-module: byte_timeout. Parameter TIMEOUT_CYCLES; ports clk, reset, clear, run, expire_o. Reusable for uart_rx frame recovery.

Test Plan:
- Write, then read back:
  - Send 57 03 A5 -> tx 06; regs_o[31:24]=A5 one cycle after the 3rd strobe.
  - Then send 52 03 -> tx A5.
- Out of range (NUM_REGS=8):
  - Send 57 08 FF -> tx 15; regs_o unchanged.
  - Send 52 09 -> tx 15.
- Bad command:
  - Send 41 -> tx 15 one cycle later; next 52 00 -> tx 00 (REG_RESET).
- Backpressure/overrun:
  - Hold tx_ready=0 for 50 cycles after 52 00; inject byte 57 during RESP.
  - Expect tx_valid held with tx_data=00, overrun_o pulses once, and no write occurs.
- Timeout (TIMEOUT_CYCLES=16):
  - Send 57 02 then idle 16 cycles -> timeout_o pulse, state IDLE, no tx.
  - Next 52 02 -> tx REG_RESET.
- Async reset:
  - After 57 01 77 -> 06, assert reset mid-frame during 57 01.
  - Expect regs_o all REG_RESET immediately, tx_valid=0, and no response after release.
